// File: rtl/pci_read_target.sv
// PCI memory-read target: decodes a 64-byte window at BASE_ADDR and serves
// reads from a 16x32 store that is loaded over a separate local port.
module pci_read_target #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        FRAME,
   input  logic        IRDY,
   input  logic [3:0]  C_BE,
   input  logic [31:0] AD_in,
   output logic [31:0] AD_out,
   output logic        AD_oe,
   output logic        DEVSEL,
   output logic        TRDY,
   output logic        STOP,
   output logic        CTL_oe,
   input  logic        ld_we,
   input  logic [3:0]  ld_addr,
   input  logic [31:0] ld_data
);

   typedef enum logic [2:0] {IDLE, TURN, DATA, DISC, BACKOFF} state_t;

   localparam logic [3:0] CMD_MEM_READ = 4'b0110;
   localparam logic [3:0] LAST_IDX     = 4'd15;

   state_t      state, next_state;
   logic [31:0] mem [16];
   logic [3:0]  idx;
   logic        frame_q;
   logic        addr_phase;
   logic        hit;
   logic        transfer;
   logic        advance;

   // NOTE: the store has no reset on purpose; contents must survive rst_n,
   // and leaving it out lets synthesis map it to plain RAM/register file.
   always_ff @(posedge clk) begin
      if (ld_we)
         mem[ld_addr] <= ld_data;
   end

   assign addr_phase = (state == IDLE) && !FRAME && frame_q;
   assign hit        = (C_BE == CMD_MEM_READ) &&
                       (AD_in[31:6] == BASE_ADDR[31:6]) &&
                       (AD_in[1:0] == 2'b00);
   assign transfer   = (state == DATA) && !IRDY;
   assign advance    = transfer && !FRAME && (idx != LAST_IDX);

   // NOTE: every register here uses <= so all of them see pre-edge values;
   // this is also what makes a same-edge ld write return the old word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         AD_out  <= '0;
         frame_q <= 1'b1;
      end else begin
         state   <= next_state;
         frame_q <= FRAME;
         if (addr_phase && hit)
            idx <= AD_in[5:2];
         if (state == TURN)
            AD_out <= mem[idx];
         else if (advance) begin
            idx    <= idx + 4'd1;
            AD_out <= mem[idx + 4'd1];
         end
      end
   end

   // NOTE: defaults first so every path assigns every output (no latches).
   always_comb begin
      next_state = state;
      DEVSEL     = 1'b1;
      TRDY       = 1'b1;
      STOP       = 1'b1;
      CTL_oe     = 1'b0;
      AD_oe      = 1'b0;
      unique case (state)
         IDLE: begin
            if (addr_phase && hit)
               next_state = TURN;
         end
         TURN: begin
            DEVSEL     = 1'b0;
            CTL_oe     = 1'b1;
            next_state = DATA;
         end
         DATA: begin
            DEVSEL = 1'b0;
            TRDY   = 1'b0;
            STOP   = (idx != LAST_IDX);
            CTL_oe = 1'b1;
            AD_oe  = 1'b1;
            if (transfer) begin
               if (FRAME)
                  next_state = BACKOFF;
               else if (idx == LAST_IDX)
                  next_state = DISC;
            end
         end
         DISC: begin
            DEVSEL = 1'b0;
            STOP   = 1'b0;
            CTL_oe = 1'b1;
            if (FRAME)
               next_state = BACKOFF;
         end
         BACKOFF: begin
            // Drive the control lines high for one cycle before releasing them.
            CTL_oe     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: doc/pci_read_target.md
PCI_READ_TARGET -- requirements
Module: pci_read_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, 64-byte-aligned base of the decoded window.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 FRAME  input  1  initiator FRAME, active-low.
REQ-005 IRDY  input  1  initiator ready, active-low.
REQ-006 C_BE  input  4  command during the address phase.
REQ-007 AD_in  input  32  address/data bus as sampled.
REQ-008 AD_out  output  32  read data driven by the target.
REQ-009 AD_oe  output  1  high = target drives AD.
REQ-010 DEVSEL  output  1  device select, active-low.
REQ-011 TRDY  output  1  target ready, active-low.
REQ-012 STOP  output  1  target disconnect request, active-low.
REQ-013 CTL_oe  output  1  high = target drives DEVSEL/TRDY/STOP.
REQ-014 ld_we  input  1  local load strobe for the data store.
REQ-015 ld_addr  input  4  local load word index.
REQ-016 ld_data  input  32  local load data.

Function
REQ-017 The block SHALL hold a 16x32 data store, written at the clock edge when ld_we=1 (mem[ld_addr]<=ld_data), at any time, regardless of bus state.
REQ-018 The block SHALL register FRAME each cycle as frame_q; an address phase is an edge with FRAME=0 and frame_q=1 while in IDLE.
REQ-019 Hit: C_BE=4'b0110 (memory read), AD_in[31:6]=BASE_ADDR[31:6], AD_in[1:0]=2'b00; index idx<=AD_in[5:2].
REQ-020 States SHALL be IDLE, TURN, DATA, DISC, BACKOFF.
REQ-021 IDLE: DEVSEL/TRDY/STOP=1, CTL_oe=0, AD_oe=0; address phase with hit -> TURN; miss -> stay IDLE (no response, master abort left to initiator).
REQ-022 TURN (exactly 1 cycle, AD turnaround): DEVSEL=0, TRDY=1, STOP=1, CTL_oe=1, AD_oe=0; AD_out<=mem[idx]; -> DATA.
REQ-023 DATA: DEVSEL=0, TRDY=0, AD_oe=1, CTL_oe=1; STOP=0 iff idx=15 (disconnect-with-data), else 1.
REQ-024 Transfer = edge in DATA with IRDY=0; no transfer while IRDY=1 (AD_out, idx held, wait states unlimited).
REQ-025 On transfer with FRAME=1 (last data phase) -> BACKOFF.
REQ-026 On transfer with FRAME=0 and idx<15: idx<=idx+1, AD_out<=mem[idx+1], stay DATA (zero-wait burst, one word per edge).
REQ-027 On transfer with FRAME=0 and idx=15: -> DISC (no wrap-around).
REQ-028 DISC: DEVSEL=0, TRDY=1, STOP=0, AD_oe=0, CTL_oe=1; when FRAME=1 -> BACKOFF.
REQ-029 BACKOFF (exactly 1 cycle): DEVSEL=1, TRDY=1, STOP=1, CTL_oe=1, AD_oe=0; -> IDLE.
REQ-030 AD_out is registered; an ld write to the word currently on AD_out SHALL NOT change AD_out until the next AD_out load; ld write and AD_out load of the same index on one edge SHALL load the old value.
REQ-031 Address phase occurring in BACKOFF SHALL be ignored (fast back-to-back not supported).

Reset
REQ-032 rst_n=0 at an edge SHALL force: state=IDLE, DEVSEL=1, TRDY=1, STOP=1, AD_oe=0, CTL_oe=0, AD_out=0, idx=0, frame_q=1, including mid-transaction.
REQ-033 Reset SHALL NOT alter data store contents.

Verification
REQ-034 Load mem[2]=32'hA5A5_0002; single read at 32'h0000_1008, FRAME high with IRDY=0 in first data phase -> DEVSEL low at edge k+1, AD_out=32'hA5A5_0002/TRDY=0 at edge k+2, BACKOFF one cycle, IDLE.
REQ-035 Burst from 32'h0000_1000, 4 words, IRDY=0 throughout, mem[i]=i -> AD_out 0,1,2,3 on consecutive cycles, then BACKOFF.
REQ-036 Burst from 32'h0000_1038 (idx 14) continuing -> words 14,15 transferred, STOP=0 with word 15, DISC until FRAME=1, then BACKOFF.
REQ-037 Read at 32'h0000_2000 or C_BE=4'b0111 -> DEVSEL, CTL_oe, AD_oe never asserted.
REQ-038 IRDY=1 for 3 cycles mid-burst -> AD_out/idx held, TRDY stays 0; resumes next word on IRDY=0.
REQ-039 rst_n=0 during DATA -> next edge all outputs at reset values; a following hit read returns previously loaded data.
